// File: rtl/vga_pkg.sv
// Shared pixel type, FIFO state encoding and colour constants for the vga pixel path.
package vga_pkg;

  typedef struct packed {
    logic [3:0] r;
    logic [3:0] g;
    logic [3:0] b;
  } rgb12_t;

  typedef enum logic [1:0] {
    WAIT_SOF = 2'd0,
    FILL     = 2'd1,
    RUN      = 2'd2
  } fifo_state_t;

  localparam rgb12_t RGB_BLACK = 12'h000;

endpackage

// File: rtl/vga_fifo_ram.sv
// DEPTH x 12 pixel store: synchronous write port, combinational read port.
module vga_fifo_ram
  import vga_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          i_wr_en,
  input  logic [AW-1:0] i_wr_addr,
  input  rgb12_t        i_wr_dat,
  input  logic [AW-1:0] i_rd_addr,
  output rgb12_t        o_rd_dat
);

  rgb12_t r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (i_wr_en) r_mem[i_wr_addr] <= i_wr_dat;
  end

  assign o_rd_dat = r_mem[i_rd_addr];

endmodule

// File: rtl/vga_pixel_fifo.sv
// Pixel elastic buffer ahead of the vga output stage: SOF alignment, prefill, 1-cycle registered colour.
// Define VGA_FIFO_STATS_EN to add the saturating underrun_cnt output.
module vga_pixel_fifo
  import vga_pkg::*;
#(
  parameter int DEPTH   = 16,
  parameter int PREFILL = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [11:0]              in_rgb,
  input  logic                     in_valid,
  input  logic                     in_sof,
  output logic                     in_ready,
  input  logic                     frame_start,
  input  logic                     de,
  output logic [3:0]               r,
  output logic [3:0]               g,
  output logic [3:0]               b,
  output logic                     underflow,
  output logic [$clog2(DEPTH):0]   level
`ifdef VGA_FIFO_STATS_EN
  ,
  output logic [15:0]              underrun_cnt
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [LW-1:0] r_level;
  fifo_state_t   r_state;
  rgb12_t        r_pix;
  logic          r_underflow;

  logic          w_full;
  logic          w_empty;
  logic          w_push;
  logic          w_wr_en;
  logic          w_pop;
  logic          w_underrun;
  logic [LW-1:0] w_level_nxt;
  fifo_state_t   w_state_nxt;
  rgb12_t        w_rd_dat;

  assign w_full  = (r_level == LW'(DEPTH));
  assign w_empty = (r_level == '0);

  always_comb begin
    in_ready = 1'b0;
    if (reset) in_ready = (r_state == WAIT_SOF) ? 1'b1 : !w_full;
  end

  // frame_start overrides everything: the handshake completes but nothing is stored or popped.
  assign w_push     = in_valid && in_ready;
  assign w_wr_en    = w_push && !frame_start && ((r_state != WAIT_SOF) || in_sof);
  assign w_pop      = de && (r_state == RUN) && !w_empty && !frame_start;
  assign w_underrun = de && (r_state == RUN) && w_empty && !frame_start;

  assign w_level_nxt = r_level + LW'(w_wr_en) - LW'(w_pop);

  always_comb begin
    w_state_nxt = r_state;
    if (frame_start) begin
      w_state_nxt = WAIT_SOF;
    end else begin
      case (r_state)
        WAIT_SOF: if (w_wr_en) w_state_nxt = FILL;
        FILL:     if (w_level_nxt >= LW'(PREFILL)) w_state_nxt = RUN;
        default:  w_state_nxt = r_state;
      endcase
    end
  end

  vga_fifo_ram #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_ram (
    .clk       (clk),
    .i_wr_en   (w_wr_en),
    .i_wr_addr (r_wr_ptr),
    .i_wr_dat  (in_rgb),
    .i_rd_addr (r_rd_ptr),
    .o_rd_dat  (w_rd_dat)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_level     <= '0;
      r_state     <= WAIT_SOF;
      r_pix       <= RGB_BLACK;
      r_underflow <= 1'b0;
    end else if (frame_start) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_level     <= '0;
      r_state     <= WAIT_SOF;
      r_pix       <= RGB_BLACK;
      r_underflow <= 1'b0;
    end else begin
      if (w_wr_en) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)   r_rd_ptr <= r_rd_ptr + 1'b1;
      r_level     <= w_level_nxt;
      r_state     <= w_state_nxt;
      r_pix       <= w_pop ? w_rd_dat : RGB_BLACK;
      r_underflow <= r_underflow || w_underrun;
    end
  end

`ifdef VGA_FIFO_STATS_EN
  logic [15:0] r_underrun_cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_underrun_cnt <= '0;
    end else if (frame_start) begin
      r_underrun_cnt <= '0;
    end else if (w_underrun && (r_underrun_cnt != 16'hFFFF)) begin
      r_underrun_cnt <= r_underrun_cnt + 16'd1;
    end
  end

  assign underrun_cnt = r_underrun_cnt;
`endif

  assign r         = r_pix.r;
  assign g         = r_pix.g;
  assign b         = r_pix.b;
  assign underflow = r_underflow;
  assign level     = r_level;

endmodule

// File: tb/tb_vga_pixel_fifo.sv
// Bench for vga_pixel_fifo: directed scenarios plus random traffic against a queue-based pixel model.
module tb_vga_pixel_fifo;

  localparam int DEPTH   = 16;
  localparam int PREFILL = 8;
  localparam int LW      = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          reset;
  logic [11:0]   in_rgb;
  logic          in_valid;
  logic          in_sof;
  logic          in_ready;
  logic          frame_start;
  logic          de;
  logic [3:0]    r;
  logic [3:0]    g;
  logic [3:0]    b;
  logic          underflow;
  logic [LW-1:0] level;
`ifdef VGA_FIFO_STATS_EN
  logic [15:0]   underrun_cnt;
`endif

  vga_pixel_fifo #(
    .DEPTH   (DEPTH),
    .PREFILL (PREFILL)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .in_rgb       (in_rgb),
    .in_valid     (in_valid),
    .in_sof       (in_sof),
    .in_ready     (in_ready),
    .frame_start  (frame_start),
    .de           (de),
    .r            (r),
    .g            (g),
    .b            (b),
    .underflow    (underflow)
`ifdef VGA_FIFO_STATS_EN
    ,
    .underrun_cnt (underrun_cnt)
`endif
    ,
    .level        (level)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: mode 0 = waiting for SOF, 1 = prefilling, 2 = releasing.
  logic [11:0] mq[$];
  int          m_mode = 0;
  logic [11:0] m_rgb  = 12'h000;
  logic        m_uf   = 1'b0;
  int          m_cnt  = 0;
  logic        m_popped;
  logic        m_wrote;

  logic [11:0] sent[$];
  logic [11:0] dut_out[$];

  function automatic logic m_ready();
    return (m_mode == 0) || (mq.size() < DEPTH);
  endfunction

  task automatic model_reset();
    mq.delete();
    m_mode = 0;
    m_rgb  = 12'h000;
    m_uf   = 1'b0;
    m_cnt  = 0;
  endtask

  task automatic cycle(input logic v, input logic s, input logic [11:0] px,
                       input logic d, input logic fs);
    logic did_push;
    int   old_mode;
    in_valid    = v;
    in_sof      = s;
    in_rgb      = px;
    de          = d;
    frame_start = fs;
    did_push    = v && m_ready();
    m_popped    = 1'b0;
    m_wrote     = 1'b0;
    @(posedge clk);
    old_mode = m_mode;
    if (fs) begin
      model_reset();
    end else begin
      m_rgb = 12'h000;
      if (d && old_mode == 2) begin
        if (mq.size() > 0) begin
          m_rgb    = mq.pop_front();
          m_popped = 1'b1;
        end else begin
          m_uf = 1'b1;
          if (m_cnt < 65535) m_cnt++;
        end
      end
      if (did_push && (old_mode != 0 || s)) begin
        mq.push_back(px);
        m_wrote = 1'b1;
        if (old_mode == 0) m_mode = 1;
      end
      if (old_mode == 1 && mq.size() >= PREFILL) m_mode = 2;
    end
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0; in_valid = 1'b1; in_sof = 1'b0; in_rgb = 12'hABC;
    de = 1'b1; frame_start = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_checks++; if (in_ready !== 1'b0) begin n_errors++; $display("FAIL reset_ready got %b want 0", in_ready); end
    n_checks++; if ({r, g, b} !== 12'h000) begin n_errors++; $display("FAIL reset_rgb got %h want 000", {r, g, b}); end
    n_checks++; if (level !== '0) begin n_errors++; $display("FAIL reset_level got %0d want 0", level); end
    n_checks++; if (underflow !== 1'b0) begin n_errors++; $display("FAIL reset_uf got %b want 0", underflow); end
    reset = 1'b1;
    #1;
    n_checks++; if (in_ready !== 1'b1) begin n_errors++; $display("FAIL release_ready got %b want 1", in_ready); end
  endtask

  task automatic test_sof_align();
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 12'($urandom_range(1, 12'hEFF)), 1'b0, 1'b0);
    n_checks++; if (level !== LW'(0)) begin n_errors++; $display("FAIL sof_discard got %0d want 0", level); end
    cycle(1'b1, 1'b1, 12'hF00, 1'b0, 1'b0);
    n_checks++; if (level !== LW'(1)) begin n_errors++; $display("FAIL sof_write got %0d want 1", level); end
    for (int i = 0; i < 7; i++) begin
      cycle(1'b1, 1'b0, 12'($urandom), 1'($urandom), 1'b0);
      n_checks++; if ({r, g, b} !== 12'h000 || underflow !== 1'b0) begin
        n_errors++; $display("FAIL fill_black got rgb=%h uf=%b want 000/0", {r, g, b}, underflow);
      end
    end
    n_checks++; if (level !== LW'(PREFILL)) begin n_errors++; $display("FAIL prefill_level got %0d want %0d", level, PREFILL); end
    cycle(1'b0, 1'b0, 12'h000, 1'b1, 1'b0);
    n_checks++; if (r !== 4'hF || g !== 4'h0 || b !== 4'h0) begin
      n_errors++; $display("FAIL first_pixel got %h want F00", {r, g, b});
    end
  endtask

  task automatic test_full();
    for (int i = 0; i < 9; i++) cycle(1'b1, 1'b0, 12'($urandom), 1'b0, 1'b0);
    n_checks++; if (level !== LW'(DEPTH) || in_ready !== 1'b0) begin
      n_errors++; $display("FAIL full got level=%0d rdy=%b want %0d/0", level, in_ready, DEPTH);
    end
    cycle(1'b1, 1'b0, 12'h5A5, 1'b0, 1'b0);
    n_checks++; if (level !== LW'(DEPTH)) begin n_errors++; $display("FAIL full_hold got %0d want %0d", level, DEPTH); end
    cycle(1'b0, 1'b0, 12'h000, 1'b1, 1'b0);
    n_checks++; if (level !== LW'(DEPTH - 1) || in_ready !== 1'b1 || {r, g, b} !== m_rgb) begin
      n_errors++; $display("FAIL full_pop got level=%0d rdy=%b rgb=%h want %0d/1/%h", level, in_ready, {r, g, b}, DEPTH - 1, m_rgb);
    end
    cycle(1'b1, 1'b0, 12'($urandom), 1'b1, 1'b0);
    n_checks++; if (level !== LW'(DEPTH - 1) || {r, g, b} !== m_rgb) begin
      n_errors++; $display("FAIL push_pop got level=%0d rgb=%h want %0d/%h", level, {r, g, b}, DEPTH - 1, m_rgb);
    end
  endtask

  task automatic test_underrun();
    for (int i = 0; i < DEPTH - 1; i++) begin
      cycle(1'b0, 1'b0, 12'h000, 1'b1, 1'b0);
      n_checks++; if ({r, g, b} !== m_rgb) begin n_errors++; $display("FAIL drain[%0d] got %h want %h", i, {r, g, b}, m_rgb); end
    end
    n_checks++; if (level !== LW'(0) || underflow !== 1'b0) begin
      n_errors++; $display("FAIL drained got level=%0d uf=%b want 0/0", level, underflow);
    end
    for (int i = 0; i < 3; i++) begin
      cycle(1'b0, 1'b0, 12'h000, 1'b1, 1'b0);
      n_checks++; if ({r, g, b} !== 12'h000 || underflow !== 1'b1) begin
        n_errors++; $display("FAIL underrun[%0d] got rgb=%h uf=%b want 000/1", i, {r, g, b}, underflow);
      end
    end
`ifdef VGA_FIFO_STATS_EN
    n_checks++; if (underrun_cnt !== 16'd3) begin n_errors++; $display("FAIL underrun_cnt got %0d want 3", underrun_cnt); end
`endif
    cycle(1'b0, 1'b0, 12'h000, 1'b0, 1'b0);
    n_checks++; if (underflow !== 1'b1) begin n_errors++; $display("FAIL uf_sticky got %b want 1", underflow); end
  endtask

  task automatic test_frame_start();
    for (int i = 0; i < 10; i++) cycle(1'b1, 1'b0, 12'($urandom), 1'b0, 1'b0);
    n_checks++; if (level !== LW'(10)) begin n_errors++; $display("FAIL fs_pre_level got %0d want 10", level); end
    cycle(1'b1, 1'b0, 12'hBAD, 1'b1, 1'b1);
    n_checks++; if (level !== LW'(0) || underflow !== 1'b0 || {r, g, b} !== 12'h000) begin
      n_errors++; $display("FAIL fs_flush got level=%0d uf=%b rgb=%h want 0/0/000", level, underflow, {r, g, b});
    end
`ifdef VGA_FIFO_STATS_EN
    n_checks++; if (underrun_cnt !== 16'd0) begin n_errors++; $display("FAIL fs_cnt got %0d want 0", underrun_cnt); end
`endif
    cycle(1'b1, 1'b0, 12'h123, 1'b0, 1'b0);
    n_checks++; if (level !== LW'(0) || in_ready !== 1'b1) begin
      n_errors++; $display("FAIL fs_wait got level=%0d rdy=%b want 0/1", level, in_ready);
    end
  endtask

  task automatic test_wrap();
    logic [11:0] px;
    sent.delete();
    dut_out.delete();
    for (int i = 0; i < 48; i++) begin
      px = (i == 0) ? 12'h0F0 : 12'($urandom);
      cycle(1'b1, (i == 0), px, (i >= PREFILL), 1'b0);
      if (m_wrote) sent.push_back(px);
      if (m_popped) dut_out.push_back({r, g, b});
    end
    for (int i = 0; i < 2 * DEPTH && mq.size() > 0; i++) begin
      cycle(1'b0, 1'b0, 12'h000, 1'b1, 1'b0);
      if (m_popped) dut_out.push_back({r, g, b});
    end
    n_checks++; if (sent.size() != 48 || dut_out.size() != 48) begin
      n_errors++; $display("FAIL wrap_count got sent=%0d out=%0d want 48/48", sent.size(), dut_out.size());
    end
    for (int i = 0; i < 48 && i < dut_out.size() && i < sent.size(); i++) begin
      n_checks++; if (dut_out[i] !== sent[i]) begin
        n_errors++; $display("FAIL wrap_order[%0d] got %h want %h", i, dut_out[i], sent[i]);
      end
    end
  endtask

  task automatic test_random();
    logic fs;
    for (int i = 0; i < 400; i++) begin
      n_checks++; if (in_ready !== m_ready()) begin
        n_errors++; $display("FAIL rnd_ready[%0d] got %b want %b", i, in_ready, m_ready());
      end
      fs = ($urandom_range(0, 63) == 0);
      cycle(($urandom_range(0, 3) != 0), ($urandom_range(0, 15) == 0), 12'($urandom),
            ($urandom_range(0, 2) != 0), fs);
      n_checks++; if ({r, g, b} !== m_rgb || level !== LW'(mq.size()) || underflow !== m_uf) begin
        n_errors++; $display("FAIL rnd_out[%0d] got rgb=%h lvl=%0d uf=%b want %h/%0d/%b",
                             i, {r, g, b}, level, underflow, m_rgb, mq.size(), m_uf);
      end
`ifdef VGA_FIFO_STATS_EN
      n_checks++; if (underrun_cnt !== 16'(m_cnt)) begin
        n_errors++; $display("FAIL rnd_cnt[%0d] got %0d want %0d", i, underrun_cnt, m_cnt);
      end
`endif
    end
  endtask

  task automatic test_async_reset();
    for (int i = 0; i < 6; i++) cycle(1'b1, (i == 0), 12'($urandom), 1'b0, 1'b0);
    reset = 1'b0;
    #1;
    model_reset();
    n_checks++; if (level !== LW'(0) || in_ready !== 1'b0 || {r, g, b} !== 12'h000 || underflow !== 1'b0) begin
      n_errors++; $display("FAIL async_reset got lvl=%0d rdy=%b rgb=%h uf=%b want 0/0/000/0",
                           level, in_ready, {r, g, b}, underflow);
    end
    @(posedge clk);
    #1;
    reset = 1'b1;
    cycle(1'b0, 1'b0, 12'h000, 1'b1, 1'b0);
    n_checks++; if ({r, g, b} !== 12'h000 || level !== LW'(0)) begin
      n_errors++; $display("FAIL post_reset got rgb=%h lvl=%0d want 000/0", {r, g, b}, level);
    end
  endtask

  initial begin
    test_reset();
    test_sof_align();
    test_full();
    test_underrun();
    test_frame_start();
    test_wrap();
    test_random();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
